// File: rtl/axis_capture_pkg.sv
// ---------------------------------------------------------------------------
// axis_capture_pkg
// Shared types and default sizing for the AXI4-Stream capture block.
//   cap_state_t        : capture controller state encoding
//   *_DEF constants    : default stream width, stored sample width, depth
//   strb_bytes()       : number of tstrb bits that qualify the stored sample
// ---------------------------------------------------------------------------
package axis_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } cap_state_t;

    localparam int TDATA_W_DEF    = 32;
    localparam int SAMPLE_W_DEF   = 16;
    localparam int NUM_POINTS_DEF = 1024;

    // A stored sample of sw bits is covered by the lowest ceil(sw/8) strobes.
    function automatic int strb_bytes(input int sw);
        return (sw + 7) / 8;
    endfunction

endpackage

// File: rtl/axis_capture_if.sv
// ---------------------------------------------------------------------------
// axis_capture_if
// AXI4-Stream beat channel (no tkeep/tid/tdest/tuser).
//   tdata  : TDATA_W-bit beat payload
//   tstrb  : byte qualifiers
//   tlast  : end of block marker
//   tvalid : beat valid (master)
//   tready : beat accepted when tvalid && tready (slave)
// ---------------------------------------------------------------------------
interface axis_capture_if #(
    parameter int TDATA_W = 32
);
    logic [TDATA_W-1:0]   tdata;
    logic [TDATA_W/8-1:0] tstrb;
    logic                 tlast;
    logic                 tvalid;
    logic                 tready;

    modport master (
        output tdata, tstrb, tlast, tvalid,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tlast, tvalid,
        output tready
    );
endinterface

// File: rtl/axis_capture_ram.sv
// ---------------------------------------------------------------------------
// capture_ram
// Simple dual-port sample store: one write port, one registered read port.
// Read-first: a read and a write to the same address in one cycle return the
// previously stored word. The array itself is never reset; only the read
// output register is cleared by rst.
//   clk    : clock
//   rst    : sync active-high reset of the read output register
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable
//   raddr  : read address
//   rdata  : registered read data (holds when re is low)
// ---------------------------------------------------------------------------
module capture_ram #(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Non-blocking update of mem makes a same-cycle read see the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/axis_capture.sv
// ---------------------------------------------------------------------------
// axis_capture
// AXI4-Stream sink that captures a fixed-length block of samples into
// on-chip memory and exposes them through a 1-cycle registered read port.
//   s_axis_aclk    : sole clock, rising edge
//   s_axis_areset  : synchronous active-high reset
//   s_axis         : stream slave (tdata/tstrb/tlast/tvalid in, tready out)
//   start          : one-cycle pulse, arms a capture from IDLE or DONE
//   stop_on_tlast  : sampled at start; end capture on an accepted tlast
//   busy           : capture in progress
//   done           : capture complete, held until next start or reset
//   count          : samples captured so far
//   strb_err       : sticky, a beat arrived with a sample-covering strobe low
//   rd_en/rd_addr  : read request
//   rd_data        : read result, valid with rd_valid one cycle after rd_en
// ---------------------------------------------------------------------------
module axis_capture
    import axis_capture_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = TDATA_W_DEF,
    parameter int SAMPLE_WIDTH         = SAMPLE_W_DEF,
    parameter int NUM_POINTS           = NUM_POINTS_DEF,
    parameter int ADDR_WIDTH           = $clog2(NUM_POINTS)
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_areset,
    axis_capture_if.slave           s_axis,
    input  logic                    start,
    input  logic                    stop_on_tlast,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH:0]     count,
    output logic                    strb_err,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [SAMPLE_WIDTH-1:0] rd_data,
    output logic                    rd_valid
);

    localparam int                STRB_BYTES = strb_bytes(SAMPLE_WIDTH);
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(NUM_POINTS - 1);

    cap_state_t state, state_nxt;

    logic [C_S_AXIS_TDATA_WIDTH-1:0]   tdata_w;
    logic [C_S_AXIS_TDATA_WIDTH/8-1:0] tstrb_w;
    logic                              unused_bits;

    logic                  stop_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  strb_err_q;
    logic                  rd_valid_q;
    logic                  hs;
    logic                  final_beat;
    logic                  arm;
    logic                  strb_bad;

    assign tdata_w = s_axis.tdata;
    assign tstrb_w = s_axis.tstrb;
    // Upper payload bits and upper strobes are intentionally discarded.
    assign unused_bits = ^{tdata_w, tstrb_w};

    // tready/busy/done decode the state register, so they change only on
    // the edge after start or after the final handshake.
    assign s_axis.tready = (state == CAPTURE);
    assign busy          = (state == CAPTURE);
    assign done          = (state == DONE);

    assign hs         = s_axis.tvalid && s_axis.tready;
    assign final_beat = hs && ((count_q == LAST_IDX) || (s_axis.tlast && stop_q));
    assign arm        = start && (state != CAPTURE);
    assign strb_bad   = ~&tstrb_w[STRB_BYTES-1:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)      state_nxt = CAPTURE;
            CAPTURE: if (final_beat) state_nxt = DONE;
            DONE:    if (start)      state_nxt = CAPTURE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state      <= IDLE;
            stop_q     <= 1'b0;
            count_q    <= '0;
            strb_err_q <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            rd_valid_q <= rd_en;
            if (arm) begin
                stop_q     <= stop_on_tlast;
                count_q    <= '0;
                strb_err_q <= 1'b0;
            end else if (hs) begin
                count_q <= count_q + (ADDR_WIDTH+1)'(1);
                if (strb_bad) begin
                    strb_err_q <= 1'b1;
                end
            end
        end
    end

    assign count    = count_q;
    assign strb_err = strb_err_q;
    assign rd_valid = rd_valid_q;

    // Writes are blocked during the reset cycle so an abort never stores.
    capture_ram #(
        .DEPTH  (NUM_POINTS),
        .WIDTH  (SAMPLE_WIDTH),
        .ADDR_W (ADDR_WIDTH)
    ) u_ram (
        .clk   (s_axis_aclk),
        .rst   (s_axis_areset),
        .we    (hs && !s_axis_areset),
        .waddr (count_q[ADDR_WIDTH-1:0]),
        .wdata (tdata_w[SAMPLE_WIDTH-1:0]),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_axis_capture.sv
// ---------------------------------------------------------------------------
// tb_axis_capture
// Randomized stream stimulus with a scoreboard on the read port and a
// behavioural capture model (accepted-beat limit and sample memory image).
// ---------------------------------------------------------------------------
module tb_axis_capture;

    localparam int NP = 1024;
    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          start;
    logic          stop_on_tlast;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          strb_err;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic          rd_valid;

    axis_capture_if #(.TDATA_W(32)) s_axis_if ();

    axis_capture dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis        (s_axis_if.slave),
        .start         (start),
        .stop_on_tlast (stop_on_tlast),
        .busy          (busy),
        .done          (done),
        .count         (count),
        .strb_err      (strb_err),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] ref_mem [NP];
    logic [15:0] exp_q [$];
    logic [31:0] beats [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Model: how many of n offered beats a capture accepts.
    function automatic int model_limit(input int n, input bit stop, input int tlast_idx);
        int l;
        l = (n > NP) ? NP : n;
        if (stop && tlast_idx >= 0 && tlast_idx + 1 < l) l = tlast_idx + 1;
        return l;
    endfunction

    function automatic bit model_ends(input int limit, input bit stop, input int tlast_idx);
        return (limit == NP) || (stop && tlast_idx >= 0 && limit == tlast_idx + 1);
    endfunction

    // Scoreboard monitor on the read port.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", {63'd0, rd_valid}, 64'd0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("rd_data", {48'd0, rd_data}, {48'd0, e});
            end
        end
    end

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_read(input int addr);
        rd_en   = 1'b1;
        rd_addr = AW'(addr);
        exp_q.push_back(ref_mem[addr]);
        @(posedge clk); #1;
        rd_en = 1'b0;
        check("rd_latency", {63'd0, rd_valid}, 64'd1);
    endtask

    task automatic do_start(input bit stop);
        check("tready_pre_start", {63'd0, s_axis_if.tready}, 64'd0);
        start = 1'b1;
        stop_on_tlast = stop;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
        check("tready_after_start", {63'd0, s_axis_if.tready}, 64'd1);
        check("count_after_start", {53'd0, count}, 64'd0);
        check("done_after_start", {63'd0, done}, 64'd0);
        check("strb_err_after_start", {63'd0, strb_err}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tready"},   {63'd0, s_axis_if.tready}, 64'd0);
        check({tag, "_busy"},     {63'd0, busy}, 64'd0);
        check({tag, "_done"},     {63'd0, done}, 64'd0);
        check({tag, "_count"},    {53'd0, count}, 64'd0);
        check({tag, "_strb_err"}, {63'd0, strb_err}, 64'd0);
        check({tag, "_rd_valid"}, {63'd0, rd_valid}, 64'd0);
        check({tag, "_rd_data"},  {48'd0, rd_data}, 64'd0);
    endtask

    // Offers beats[0..n-1]; returns once the model limit is reached and any
    // extra beat has been refused for a bounded number of cycles.
    task automatic send_stream(input int n, input int gap, input bit stop, input int tlast_idx,
                               input int strb_idx, input int start_idx, input bit rd_same);
        int acc, limit;
        bit ends;
        acc   = 0;
        limit = model_limit(n, stop, tlast_idx);
        ends  = model_ends(limit, stop, tlast_idx);
        for (int i = 0; i < n; i++) begin
            bit got;
            got = 1'b0;
            s_axis_if.tdata  = beats[i];
            s_axis_if.tstrb  = (i == strb_idx) ? 4'b0001 : 4'b1111;
            s_axis_if.tlast  = (i == tlast_idx);
            s_axis_if.tvalid = 1'b1;
            if (i == start_idx) begin
                start = 1'b1;
                stop_on_tlast = 1'b1;
            end
            if (rd_same && i < NP) begin
                rd_en   = 1'b1;
                rd_addr = AW'(i);
                exp_q.push_back(ref_mem[i]);
            end
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                got = s_axis_if.tready;
                @(posedge clk); #1;
                start = 1'b0;
                rd_en = 1'b0;
            end
            s_axis_if.tvalid = 1'b0;
            s_axis_if.tlast  = 1'b0;
            if (!got) break;
            acc++;
            check("count_step", {53'd0, count}, 64'(acc));
            check("done_step", {63'd0, done}, {63'd0, (ends && acc == limit)});
            check("tready_step", {63'd0, s_axis_if.tready}, {63'd0, !(ends && acc == limit)});
            check("strb_err_step", {63'd0, strb_err}, {63'd0, (strb_idx >= 0 && acc > strb_idx)});
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
            end
        end
        check("accepted_beats", 64'(acc), 64'(limit));
        for (int i = 0; i < limit; i++) begin
            logic [31:0] b;
            b = beats[i];
            ref_mem[i] = b[15:0];
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        stop_on_tlast = 1'b0;
        rd_en = 1'b0;
        rd_addr = '0;
        s_axis_if.tdata  = $urandom();
        s_axis_if.tstrb  = 4'b1111;
        s_axis_if.tlast  = 1'b0;
        s_axis_if.tvalid = 1'b1;

        // Reset held 10 cycles, tvalid high throughout.
        repeat (10) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("tready_no_start", {63'd0, s_axis_if.tready}, 64'd0);
        end
        @(posedge clk); #1;
        s_axis_if.tvalid = 1'b0;

        // Full-depth continuous capture, one extra beat offered.
        beats.delete();
        for (int k = 0; k <= NP; k++) beats.push_back(($urandom() & 32'hFFFF_0000) | 32'(k & 16'hFFFF));
        do_start(1'b0);
        send_stream(NP + 1, 0, 1'b0, -1, -1, -1, 1'b0);
        check("full_count", {53'd0, count}, 64'd1024);
        check("full_busy", {63'd0, busy}, 64'd0);
        do_read(0);
        do_read(511);
        do_read(1023);
        for (int r = 0; r < 4; r++) do_read($urandom_range(NP - 1, 0));

        // stop_on_tlast with tlast on beat 99.
        beats.delete();
        for (int k = 0; k < 150; k++) beats.push_back($urandom());
        beats[99] = 32'h5A5A_0063;
        do_start(1'b1);
        send_stream(150, 0, 1'b1, 99, -1, -1, 1'b0);
        check("tlast_count", {53'd0, count}, 64'd100);
        check("tlast_done", {63'd0, done}, 64'd1);
        do_read(99);
        do_read(0);
        do_read(100);
        do_read($urandom_range(98, 1));

        // Sparse tvalid (1 in 3), ignored tlast, start pulse mid-capture.
        beats.delete();
        for (int k = 0; k <= NP; k++) beats.push_back(($urandom() & 32'hFFFF_0000) | 32'(k & 16'hFFFF));
        do_start(1'b0);
        send_stream(NP + 1, 2, 1'b0, 400, -1, 300, 1'b0);
        check("sparse_count", {53'd0, count}, 64'd1024);
        check("sparse_done", {63'd0, done}, 64'd1);
        do_read(0);
        do_read(511);
        do_read(1023);
        for (int r = 0; r < 4; r++) do_read($urandom_range(NP - 1, 0));

        // Bad strobe on beat 5, capture ended by tlast on beat 9.
        beats.delete();
        for (int k = 0; k < 12; k++) beats.push_back($urandom());
        do_start(1'b1);
        send_stream(12, 0, 1'b1, 9, 5, -1, 1'b0);
        check("strb_done", {63'd0, done}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("strb_sticky", {63'd0, strb_err}, 64'd1);
        do_read(5);

        // 500 beats then reset mid-capture.
        beats.delete();
        for (int k = 0; k < 500; k++) beats.push_back($urandom());
        do_start(1'b0);
        send_stream(500, 0, 1'b0, -1, -1, -1, 1'b0);
        check("pre_abort_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("abort");
        rst = 1'b0;

        // Four beats with same-cycle read of the write address (old data).
        beats.delete();
        beats.push_back(32'hABCD_1234);
        beats.push_back(32'h0000_0005);
        beats.push_back(32'h0000_0006);
        beats.push_back(32'h0000_0007);
        do_start(1'b0);
        send_stream(4, 0, 1'b0, -1, -1, -1, 1'b1);
        check("short_count", {53'd0, count}, 64'd4);
        do_read(0);
        do_read(1);
        do_read(3);
        do_read(4);
        do_read(499);

        repeat (3) @(posedge clk);
        #1;
        check("rd_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
